// File: rtl/cordic_vectoring_iter_pkg.sv
// Shared CORDIC constants: atan table, gain compensation, state encoding.
// Latency: n/a (constants and a pure lookup function only).
// Backpressure: n/a.
package cordic_pkg;

  // 1/K for an infinite number of micro-rotations, Q16.16 (0.607253).
  localparam logic [31:0] KINV   = 32'h00009B75;
  // 180.0 degrees, Q16.16.
  localparam logic [31:0] DEG180 = 32'h00B40000;

  // Controller states, kept as plain 2-bit constants so older tools and
  // hand-written decoders can use the same encoding.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ITER = 2'd1;
  localparam state_t S_COMP = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // round(atan(2^-i) * 180/pi * 65536): micro-rotation angle for step i.
  function automatic logic [31:0] atan_lut(input logic [3:0] i);
    logic [31:0] v;
    case (i)
      4'd0:    v = 32'h002D0000;
      4'd1:    v = 32'h001A90A7;
      4'd2:    v = 32'h000E0947;
      4'd3:    v = 32'h00072001;
      4'd4:    v = 32'h0003938B;
      4'd5:    v = 32'h0001CA38;
      4'd6:    v = 32'h0000E52A;
      4'd7:    v = 32'h00007297;
      4'd8:    v = 32'h0000394C;
      4'd9:    v = 32'h00001CA6;
      4'd10:   v = 32'h00000E53;
      4'd11:   v = 32'h00000729;
      4'd12:   v = 32'h00000395;
      4'd13:   v = 32'h000001CA;
      4'd14:   v = 32'h000000E5;
      default: v = 32'h00000073;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_vectoring_iter_if.sv
// Request/response bundle for the vectoring CORDIC: (x0, y0) in, polar out.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input and the output side.
interface cordic_vectoring_iter_if #(
  parameter int DATAWIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATAWIDTH-1:0] x0;
  logic signed [DATAWIDTH-1:0] y0;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATAWIDTH-1:0] mag;
  logic signed [DATAWIDTH-1:0] angle;
  logic signed [DATAWIDTH-1:0] y_res;

  modport master (
    output in_valid, x0, y0, out_ready,
    input  in_ready, out_valid, mag, angle, y_res
  );

  modport slave (
    input  in_valid, x0, y0, out_ready,
    output in_ready, out_valid, mag, angle, y_res
  );
endinterface

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: drives y toward zero, accumulating angle in z.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int W = 34
) (
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  input  logic        [3:0]   i,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic signed [W-1:0] at;

  // Rotate against the sign of y; both updates use the pre-rotation x and y.
  always_comb begin
    x_sh = x_in >>> i;
    y_sh = y_in >>> i;
    at   = W'(atan_lut(i));
    if (!y_in[W-1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + at;
    end else begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - at;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: Q16.16 (x0, y0) -> magnitude, angle in degrees.
// Latency: N+1 clocks from accept to out_valid; one micro-rotation per clock.
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int N         = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  cordic_vectoring_iter_if.slave bus
);

  // Two guard bits absorb the CORDIC gain (~1.65) times sqrt(2).
  localparam int                W        = DATAWIDTH + 2;
  localparam logic [3:0]        I_LAST   = 4'(N - 1);
  localparam logic signed [W-1:0] KINV_W   = W'(KINV);
  localparam logic signed [W-1:0] DEG180_W = W'(DEG180);

  state_t                      state;
  logic signed [W-1:0]         x_q;
  logic signed [W-1:0]         y_q;
  logic signed [W-1:0]         z_q;
  logic        [3:0]           i_q;
  logic                        zero_q;
  logic signed [DATAWIDTH-1:0] mag_q;
  logic signed [DATAWIDTH-1:0] angle_q;
  logic signed [DATAWIDTH-1:0] yres_q;

  logic signed [W-1:0]         x_nx;
  logic signed [W-1:0]         y_nx;
  logic signed [W-1:0]         z_nx;
  logic signed [W-1:0]         x0_w;
  logic signed [W-1:0]         y0_w;
  logic signed [W-1:0]         x_ld;
  logic signed [W-1:0]         y_ld;
  logic signed [W-1:0]         z_ld;
  logic signed [2*W-1:0]       prod;
  logic signed [DATAWIDTH-1:0] mag_d;
  logic signed [DATAWIDTH-1:0] angle_d;
  logic signed [DATAWIDTH-1:0] yres_d;
  logic                        is_zero;

  cordic_vec_stage #(
    .W (W)
  ) u_stage (
    .x_in  (x_q),
    .y_in  (y_q),
    .z_in  (z_q),
    .i     (i_q),
    .x_out (x_nx),
    .y_out (y_nx),
    .z_out (z_nx)
  );

  // Fold the left half-plane onto the right so the micro-rotations converge;
  // the 180 degree offset keeps the final angle in (-180, +180].
  always_comb begin
    x0_w    = W'(bus.x0);
    y0_w    = W'(bus.y0);
    x_ld    = x0_w;
    y_ld    = y0_w;
    z_ld    = '0;
    is_zero = (bus.x0 == '0) && (bus.y0 == '0);
    if (bus.x0[DATAWIDTH-1]) begin
      x_ld = -x0_w;
      y_ld = -y0_w;
      z_ld = bus.y0[DATAWIDTH-1] ? -DEG180_W : DEG180_W;
    end
  end

  // Gain compensation, truncated toward -inf; a zero vector has no angle.
  always_comb begin
    prod    = (2*W)'(x_q) * (2*W)'(KINV_W);
    mag_d   = DATAWIDTH'(prod >>> 16);
    angle_d = DATAWIDTH'(z_q);
    yres_d  = DATAWIDTH'(y_q);
    if (zero_q) begin
      mag_d   = '0;
      angle_d = '0;
      yres_d  = '0;
    end
  end

  // Control FSM and datapath registers: accept, iterate N times, compensate, hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
      yres_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q    <= x_ld;
            y_q    <= y_ld;
            z_q    <= z_ld;
            i_q    <= '0;
            zero_q <= is_zero;
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          i_q <= i_q + 4'd1;
          if (i_q == I_LAST) begin
            state <= S_COMP;
          end
        end
        S_COMP: begin
          mag_q   <= mag_d;
          angle_q <= angle_d;
          yres_q  <= yres_d;
          state   <= S_DONE;
        end
        default: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.mag       = mag_q;
  assign bus.angle     = angle_q;
  assign bus.y_res     = yres_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Bench for the vectoring CORDIC: directed vectors, scoreboard + monitor.
// Latency: checks N+1 clocks from accept to out_valid on every result.
// Backpressure: holds out_ready low to verify result hold and input blocking.
module tb_cordic_vectoring_iter;

  localparam int DW  = 32;
  localparam int NIT = 10;
  localparam int ATOL = 32'h1EB8;
  localparam int MTOL = 32'h83;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_vectoring_iter_if #(.DATAWIDTH(DW)) bus_if ();

  cordic_vectoring_iter #(
    .DATAWIDTH (DW),
    .N         (NIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int    mag;
    int    angle;
    int    mtol;
    int    atol;
    bit    chk_y;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_ov = 1'b0;

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if ((act - exp) > tol || (exp - act) > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Cycle counter and the cycle number right after each accept edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.in_valid && bus_if.in_ready) acc_cyc <= cyc + 1;
  end

  // Monitor: latency on every rising out_valid, compare on every handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.out_valid && !prev_ov) check("latency", cyc - acc_cyc, NIT + 1, 0);
      prev_ov = bus_if.out_valid;
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: mag=%0d angle=%0d with nothing expected", bus_if.mag, bus_if.angle);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_mag"}, bus_if.mag, mon_e.mag, mon_e.mtol);
          check({mon_e.name, "_angle"}, bus_if.angle, mon_e.angle, mon_e.atol);
          if (mon_e.chk_y) check({mon_e.name, "_yres"}, bus_if.y_res, 0, 0);
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus_if.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus_if.in_ready) begin
      total++;
      bad++;
      $display("FAIL wait_in_ready: in_ready=0 after 200 cycles, want 1");
    end
  endtask

  task automatic push_exp(input int m, input int a, input int mt, input int at, input bit cy, input string nm);
    exp_t e;
    e.mag = m; e.angle = a; e.mtol = mt; e.atol = at; e.chk_y = cy; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic send(input int x, input int y, input int m, input int a,
                      input int mt, input int at, input bit cy, input string nm);
    wait_ready();
    bus_if.x0 = x;
    bus_if.y0 = y;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    push_exp(m, a, mt, at, cy, nm);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || !bus_if.in_ready) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
    end
  endtask

  initial begin
    int t;
    bit stable;
    bit irdy_seen;
    logic signed [DW-1:0] hm, ha, hy;

    bus_if.in_valid  = 1'b0;
    bus_if.x0        = '0;
    bus_if.y0        = '0;
    bus_if.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus_if.out_valid, 0, 0);
    check("rst_mag", bus_if.mag, 0, 0);
    check("rst_angle", bus_if.angle, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus_if.in_ready, 1, 0);

    // Directed vectors, one per quadrant plus axes and the origin.
    send(32'h00010000, 32'h00000000, 32'h00010000, 32'h00000000, MTOL, ATOL, 1'b0, "x1_y0");
    send(32'h00010000, 32'h00010000, 32'h00016A0A, 32'h002D0000, MTOL, ATOL, 1'b0, "x1_y1");
    send(32'h00000000, 32'h00010000, 32'h00010000, 32'h005A0000, MTOL, ATOL, 1'b0, "x0_y1");
    send(32'hFFFF0000, 32'h00010000, 32'h00016A0A, 32'h00870000, MTOL, ATOL, 1'b0, "xm1_y1");
    send(32'hFFFF0000, 32'hFFFF0000, 32'h00016A0A, 32'hFF790000, MTOL, ATOL, 1'b0, "xm1_ym1");
    send(32'hFFFF0000, 32'h00000000, 32'h00010000, 32'h00B40000, MTOL, ATOL, 1'b0, "xm1_y0");
    send(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1'b1, "zero");
    wait_drain();

    // Backpressure: result must hold while out_ready is low.
    bus_if.out_ready = 1'b0;
    send(32'h00010000, 32'h00010000, 32'h00016A0A, 32'h002D0000, MTOL, ATOL, 1'b0, "bp_x1_y1");
    t = 0;
    while (!bus_if.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_out_valid", bus_if.out_valid, 1, 0);
    hm = bus_if.mag;
    ha = bus_if.angle;
    hy = bus_if.y_res;
    stable = 1'b1;
    irdy_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus_if.in_valid = k[0];
      bus_if.x0 = 32'h00070000;
      bus_if.y0 = 32'hFFF90000;
      @(posedge clk); #1;
      if (bus_if.mag != hm || bus_if.angle != ha || bus_if.y_res != hy || !bus_if.out_valid) stable = 1'b0;
      if (bus_if.in_ready) irdy_seen = 1'b1;
    end
    check("bp_hold_stable", stable, 1, 0);
    check("bp_in_ready_low", irdy_seen, 0, 0);

    // Release: handshake edge ignores in_valid, the next edge accepts.
    bus_if.x0 = 32'h00000000;
    bus_if.y0 = 32'h00010000;
    bus_if.in_valid = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_in_ready", bus_if.in_ready, 1, 0);
    check("hs_out_valid", bus_if.out_valid, 0, 0);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    check("next_accept", bus_if.in_ready, 0, 0);
    push_exp(32'h00010000, 32'h005A0000, MTOL, ATOL, 1'b0, "bp_next_x0_y1");
    wait_drain();

    // Reset in the middle of ITER discards the operation.
    wait_ready();
    bus_if.x0 = 32'h00010000;
    bus_if.y0 = 32'h00000000;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus_if.out_valid, 0, 0);
    check("midrst_mag", bus_if.mag, 0, 0);
    check("midrst_angle", bus_if.angle, 0, 0);
    check("midrst_yres", bus_if.y_res, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", bus_if.in_ready, 1, 0);
    check("postrst_out_valid", bus_if.out_valid, 0, 0);

    send(32'h00030000, 32'h00040000, 32'h00050000, 32'h0035214E, MTOL, ATOL, 1'b0, "x3_y4");
    wait_drain();
    repeat (20) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
